// File: rtl/frame_buffer_ctrl_pkg.sv
// Shared definitions for the trace frame store: read-FSM encoding,
// default frame width, statistic counter widths and a saturating helper.
package frame_buffer_ctrl_pkg;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_VALID = 2'd2
    } rdState_t;

    localparam int FRAME_W_DEF = 128;
    localparam int LOST_W      = 16;
    localparam int TOTAL_W     = 32;

    // Lost-frame counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [LOST_W-1:0] satInc(input logic [LOST_W-1:0] v);
        logic [LOST_W-1:0] r;
        if (v == {LOST_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_buffer_ctrl_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Callers never read and write the same address in one cycle, so no bypass.
module frame_ram
    import frame_buffer_ctrl_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = FRAME_W_DEF
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem_r [0:(1<<ADDR_W)-1];

    // Write port: commit a frame into its slot.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_r[wrAddr] <= wrData;
        end
    end

    // Read port: registered output, one cycle after the read is issued.
    always_ff @(posedge clk) begin
        if (rdEn) begin
            rdData <= mem_r[rdAddr];
        end
    end

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Trace frame store controller: sequences assembler writes and sender reads
// on a shared dual-port RAM, presents the head frame with a ready flag, and
// keeps occupancy plus lost/total frame statistics.
module frame_buffer_ctrl
    import frame_buffer_ctrl_pkg::*;
#(
    parameter int BUFFLENLOG2 = 9,
    parameter int FRAME_W     = FRAME_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FRAME_W-1:0]     WrFrame,
    input  logic                   WrStrobe,
    input  logic                   Flush,
    output logic [FRAME_W-1:0]     RdFrame,
    output logic                   RdReady,
    input  logic                   RdNext,
    output logic [BUFFLENLOG2-1:0] FramesCnt,
    output logic [LOST_W-1:0]      LostFrames,
    output logic [TOTAL_W-1:0]     TotalFrames,
    output logic                   Overflow
);

    localparam logic [BUFFLENLOG2-1:0] CNT_ZERO = {BUFFLENLOG2{1'b0}};
    localparam logic [BUFFLENLOG2-1:0] CNT_ONE  = BUFFLENLOG2'(1);
    localparam logic [BUFFLENLOG2-1:0] CNT_MAX  = {BUFFLENLOG2{1'b1}};

    logic [BUFFLENLOG2-1:0] wrPtr_r;
    logic [BUFFLENLOG2-1:0] rdPtr_r;
    rdState_t               rdState_r;
    rdState_t               rdStateNext_s;
    logic                   ramRdEn_s;
    logic [BUFFLENLOG2-1:0] ramRdAddr_s;
    logic [FRAME_W-1:0]     ramRdData_s;
    logic                   full_s;
    logic                   consume_s;
    logic                   accept_s;
    logic                   drop_s;

    // Write/consume qualification; a consume frees a slot before a same-cycle write.
    always_comb begin
        full_s    = (FramesCnt == CNT_MAX);
        consume_s = (rdState_r == RD_VALID) && RdNext && !Flush;
        accept_s  = WrStrobe && !Flush && (!full_s || consume_s);
        drop_s    = WrStrobe && !Flush && full_s && !consume_s;
    end

    // Read FSM next state and RAM read issue; reads only target committed slots.
    always_comb begin
        rdStateNext_s = rdState_r;
        ramRdEn_s     = 1'b0;
        ramRdAddr_s   = rdPtr_r;
        if (Flush) begin
            rdStateNext_s = RD_IDLE;
        end else begin
            case (rdState_r)
                RD_IDLE: begin
                    if (FramesCnt != CNT_ZERO) begin
                        ramRdEn_s     = 1'b1;
                        rdStateNext_s = RD_FETCH;
                    end else begin
                        rdStateNext_s = RD_IDLE;
                    end
                end
                RD_FETCH: begin
                    rdStateNext_s = RD_VALID;
                end
                RD_VALID: begin
                    if (consume_s) begin
                        if (FramesCnt != CNT_ONE) begin
                            ramRdEn_s     = 1'b1;
                            ramRdAddr_s   = rdPtr_r + CNT_ONE;
                            rdStateNext_s = RD_FETCH;
                        end else begin
                            rdStateNext_s = RD_IDLE;
                        end
                    end else begin
                        rdStateNext_s = RD_VALID;
                    end
                end
                default: begin
                    rdStateNext_s = RD_IDLE;
                end
            endcase
        end
    end

    // Read side registers: FSM state, read pointer, presented head frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdState_r <= RD_IDLE;
            rdPtr_r   <= CNT_ZERO;
            RdReady   <= 1'b0;
            RdFrame   <= {FRAME_W{1'b0}};
        end else begin
            rdState_r <= rdStateNext_s;
            if (Flush) begin
                rdPtr_r <= CNT_ZERO;
                RdReady <= 1'b0;
            end else if (rdState_r == RD_FETCH) begin
                RdFrame <= ramRdData_s;
                RdReady <= 1'b1;
            end else if (consume_s) begin
                rdPtr_r <= rdPtr_r + CNT_ONE;
                RdReady <= 1'b0;
            end
        end
    end

    // Write side registers: write pointer, occupancy and frame statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_r     <= CNT_ZERO;
            FramesCnt   <= CNT_ZERO;
            LostFrames  <= {LOST_W{1'b0}};
            TotalFrames <= {TOTAL_W{1'b0}};
            Overflow    <= 1'b0;
        end else begin
            TotalFrames <= TotalFrames + {{(TOTAL_W-1){1'b0}}, WrStrobe};
            if (Flush) begin
                wrPtr_r   <= CNT_ZERO;
                FramesCnt <= CNT_ZERO;
                Overflow  <= 1'b0;
            end else begin
                if (accept_s) begin
                    wrPtr_r <= wrPtr_r + CNT_ONE;
                end
                case ({accept_s, consume_s})
                    2'b10:   FramesCnt <= FramesCnt + CNT_ONE;
                    2'b01:   FramesCnt <= FramesCnt - CNT_ONE;
                    default: FramesCnt <= FramesCnt;
                endcase
                if (drop_s) begin
                    LostFrames <= satInc(LostFrames);
                    Overflow   <= 1'b1;
                end
            end
        end
    end

    frame_ram #(
        .ADDR_W (BUFFLENLOG2),
        .DATA_W (FRAME_W)
    ) uRam (
        .clk    (clk),
        .wrEn   (accept_s),
        .wrAddr (wrPtr_r),
        .wrData (WrFrame),
        .rdEn   (ramRdEn_s),
        .rdAddr (ramRdAddr_s),
        .rdData (ramRdData_s)
    );

endmodule
